// File: rtl/flit_rx_monitor.sv
// flit_rx_monitor: receive-side sink for flit-injection energy runs.
// Delimits packets by idle gaps and reports length and toggle activity.
module flit_rx_monitor #(
    parameter int N       = 21,
    parameter int PAYLOAD = 20,
    parameter int GAP     = 7,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     input1,
    input  logic [N-1:0]     input2,
    output logic             stat_valid,
    input  logic             stat_ready,
    output logic [CNT_W-1:0] stat_len,
    output logic [CNT_W-1:0] stat_toggles,
    output logic             stat_len_err,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int FW = 2 * N;
    localparam int HW = $clog2(FW + 1);
    localparam int SW = ((CNT_W > HW) ? CNT_W : HW) + 1;
    localparam int IW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [IW-1:0] IDLE_LAST = IW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_REPORT
    } state_t;

    state_t r_state;

    logic [FW-1:0]    r_prev;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_tog;
    logic [IW-1:0]    r_idle;
    logic             r_stat_valid;
    logic [CNT_W-1:0] r_stat_len;
    logic [CNT_W-1:0] r_stat_tog;
    logic             r_stat_err;
    logic [CNT_W-1:0] r_pkt;

    logic [FW-1:0]    w_flit;
    logic [FW-1:0]    w_diff;
    logic [HW-1:0]    w_h;
    logic [SW-1:0]    w_h_ext;
    logic [SW-1:0]    w_tog_sum;
    logic [CNT_W-1:0] w_h_sat;
    logic [CNT_W-1:0] w_tog_next;
    logic [CNT_W-1:0] w_len_next;
    logic [CNT_W-1:0] w_pkt_next;
    logic             w_accept;
    logic             w_len_err;

    assign in_ready     = (r_state != S_REPORT);
    assign w_accept     = in_valid & in_ready;
    assign w_flit       = {input2, input1};
    assign w_diff       = w_flit ^ r_prev;

    assign stat_valid   = r_stat_valid;
    assign stat_len     = r_stat_len;
    assign stat_toggles = r_stat_tog;
    assign stat_len_err = r_stat_err;
    assign pkt_count    = r_pkt;

    // Hamming distance between incoming flit and previous accepted flit
    always_comb begin
        w_h = '0;
        for (int i = 0; i < FW; i++) begin
            w_h = w_h + HW'(w_diff[i]);
        end
    end

    // Saturating counter updates; toggles widened so overflow is visible
    always_comb begin
        w_h_ext    = SW'(w_h);
        w_tog_sum  = SW'(r_tog) + w_h_ext;
        w_h_sat    = (w_h_ext > SW'(MAX)) ? MAX : w_h_ext[CNT_W-1:0];
        w_tog_next = (w_tog_sum > SW'(MAX)) ? MAX : w_tog_sum[CNT_W-1:0];
        w_len_next = (r_len == MAX) ? MAX : r_len + 1'b1;
        w_pkt_next = (r_pkt == MAX) ? MAX : r_pkt + 1'b1;
        w_len_err  = (32'(r_len) != PAYLOAD);
    end

    // Packet FSM: collect flits, close on idle gap, hold report until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_len        <= '0;
            r_tog        <= '0;
            r_idle       <= '0;
            r_stat_valid <= 1'b0;
            r_stat_len   <= '0;
            r_stat_tog   <= '0;
            r_stat_err   <= 1'b0;
            r_pkt        <= '0;
        end else begin
            if (w_accept) begin
                r_prev <= w_flit;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len   <= CNT_W'(1);
                        r_tog   <= w_h_sat;
                        r_idle  <= '0;
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_len  <= w_len_next;
                        r_tog  <= w_tog_next;
                        r_idle <= '0;
                    end else if (r_idle == IDLE_LAST) begin
                        r_stat_len   <= r_len;
                        r_stat_tog   <= r_tog;
                        r_stat_err   <= w_len_err;
                        r_stat_valid <= 1'b1;
                        r_state      <= S_REPORT;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (stat_ready) begin
                        r_pkt        <= w_pkt_next;
                        r_stat_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flit_rx_monitor.sv
// tb_flit_rx_monitor: directed checks of packet delimiting,
// toggle counting, backpressure, saturation and reset.
module tb_flit_rx_monitor;

    localparam int N = 21;
    localparam int W = 16;
    localparam int SWD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [N-1:0]  input1 = '0;
    logic [N-1:0]  input2 = '0;
    logic          stat_ready = 1'b0;

    logic          in_ready;
    logic          stat_valid;
    logic [W-1:0]  stat_len;
    logic [W-1:0]  stat_toggles;
    logic          stat_len_err;
    logic [W-1:0]  pkt_count;

    logic          s_in_ready;
    logic          s_stat_valid;
    logic [SWD-1:0] s_stat_len;
    logic [SWD-1:0] s_stat_toggles;
    logic          s_stat_len_err;
    logic [SWD-1:0] s_pkt_count;

    int n_tot = 0;
    int n_bad = 0;

    localparam logic [2*N-1:0] ONES = {2*N{1'b1}};

    flit_rx_monitor #(.N(N), .PAYLOAD(20), .GAP(7), .CNT_W(W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .input1(input1), .input2(input2),
        .stat_valid(stat_valid), .stat_ready(stat_ready),
        .stat_len(stat_len), .stat_toggles(stat_toggles),
        .stat_len_err(stat_len_err), .pkt_count(pkt_count)
    );

    flit_rx_monitor #(.N(N), .PAYLOAD(20), .GAP(7), .CNT_W(SWD)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .input1(input1), .input2(input2),
        .stat_valid(s_stat_valid), .stat_ready(stat_ready),
        .stat_len(s_stat_len), .stat_toggles(s_stat_toggles),
        .stat_len_err(s_stat_len_err), .pkt_count(s_pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2*N-1:0] f);
        logic took;
        int   k;
        took = 1'b0;
        k = 0;
        in_valid = 1'b1;
        {input2, input1} = f;
        while (!took && k < 50) begin
            took = in_ready;
            step();
            k++;
        end
        if (!took) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic close_pkt(input string tag);
        idle(6);
        chk({tag, "_sv_early"}, stat_valid, 0);
        idle(1);
        chk({tag, "_sv"}, stat_valid, 1);
        chk({tag, "_rdy0"}, in_ready, 0);
    endtask

    task automatic take(input string tag, input int pk);
        stat_ready = 1'b1;
        step();
        stat_ready = 1'b0;
        chk({tag, "_sv_drop"}, stat_valid, 0);
        chk({tag, "_pkt"}, pkt_count, 64'(pk));
    endtask

    task automatic pat(input int cnt, input int start);
        for (int i = 0; i < cnt; i++)
            send(((start + i) % 2 == 0) ? 42'h3 : 42'h0);
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_sv", stat_valid, 0);
        chk("rst_len", stat_len, 0);
        chk("rst_tog", stat_toggles, 0);
        chk("rst_err", stat_len_err, 0);
        chk("rst_pkt", pkt_count, 0);

        for (int i = 0; i < 20; i++)
            send((i % 2 == 0) ? ONES : '0);
        close_pkt("alt");
        chk("alt_len", stat_len, 20);
        chk("alt_tog", stat_toggles, 840);
        chk("alt_err", stat_len_err, 0);
        chk("sat_len", s_stat_len, 15);
        chk("sat_tog", s_stat_toggles, 15);
        chk("sat_err", s_stat_len_err, 1);
        take("alt", 1);

        for (int i = 0; i < 5; i++) send('0);
        close_pkt("short");
        chk("short_len", stat_len, 5);
        chk("short_tog", stat_toggles, 0);
        chk("short_err", stat_len_err, 1);
        take("short", 2);

        pat(10, 0);
        idle(6);
        chk("gap6_sv", stat_valid, 0);
        pat(10, 10);
        close_pkt("gap6");
        chk("gap6_len", stat_len, 20);
        chk("gap6_tog", stat_toggles, 40);
        chk("gap6_err", stat_len_err, 0);
        take("gap6", 3);

        pat(10, 0);
        close_pkt("gap7a");
        chk("gap7a_len", stat_len, 10);
        chk("gap7a_tog", stat_toggles, 20);
        take("gap7a", 4);
        pat(10, 0);
        close_pkt("gap7b");
        chk("gap7b_len", stat_len, 10);
        chk("gap7b_tog", stat_toggles, 20);
        take("gap7b", 5);

        send(42'h0FF);
        send(42'h0F0);
        close_pkt("bp");
        chk("bp_len", stat_len, 2);
        chk("bp_tog", stat_toggles, 12);
        in_valid = 1'b1;
        {input2, input1} = 42'h3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_rdy", in_ready, 0);
            chk("bp_hold_sv", stat_valid, 1);
            chk("bp_hold_len", stat_len, 2);
            chk("bp_hold_tog", stat_toggles, 12);
        end
        stat_ready = 1'b1;
        step();
        stat_ready = 1'b0;
        chk("bp_pkt", pkt_count, 6);
        chk("bp_idle_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        close_pkt("bpn");
        chk("bpn_len", stat_len, 1);
        chk("bpn_tog", stat_toggles, 6);
        take("bpn", 7);

        for (int i = 0; i < 8; i++) send(ONES);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_pkt", pkt_count, 0);
        chk("mid_rst_sv", stat_valid, 0);
        chk("mid_rst_rdy", in_ready, 1);
        send(42'h1);
        send(42'h1);
        send(42'h0);
        close_pkt("mid");
        chk("mid_len", stat_len, 3);
        chk("mid_tog", stat_toggles, 2);
        chk("mid_err", stat_len_err, 1);
        chk("mid_sat_len", s_stat_len, 3);
        take("mid", 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/flit_rx_monitor.md
Name: flit_rx_monitor

Overview:
- Receiving end of the flit-injection stimulus used for datapath energy characterization.
- Accepts 2N-bit flits, presented as two N-bit halves, under a valid/ready handshake.
- Delimits packets by idle gaps, counts flits per packet, and accumulates bit-toggle activity (Hamming distance between successive flits).
- Reports per-packet statistics on a second valid/ready handshake. Sits after the flit source, beside the unit under test, as the activity/energy bookkeeping sink.

Parameters:
- N, 21: width of each flit half; a flit is 2N bits.
- PAYLOAD, 20: expected flits per packet; used for the length check.
- GAP, 7: consecutive cycles with no accepted flit that close a packet (GAP ≥ 1).
- CNT_W, 16: width of the length, toggle and packet counters.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: flit present.
- in_ready, output, 1: monitor can accept a flit.
- input1, input, N: flit bits [N-1:0].
- input2, input, N: flit bits [2N-1:N].
- stat_valid, output, 1: packet statistics available.
- stat_ready, input, 1: statistics consumer accepts.
- stat_len, output, CNT_W: flits in the reported packet.
- stat_toggles, output, CNT_W: summed Hamming distances for the reported packet.
- stat_len_err, output, 1: stat_len != PAYLOAD.
- pkt_count, output, CNT_W: number of packets reported (handshakes completed).

Behaviour:
- Reset (rst high at a rising edge) gives:
  - state IDLE; in_ready=1; stat_valid=0.
  - stat_len, stat_toggles, stat_len_err, pkt_count all 0.
  - Internal prev_flit, len, tog and idle_cnt all 0.
  - Reset overrides everything, including mid-packet or mid-REPORT. A partial packet is discarded and not reported.
- Flit accept: in_valid & in_ready at a rising edge.
  - Flit F = {input2, input1}.
  - h = popcount(F ^ prev_flit), range 0..2N.
  - prev_flit <= F on every accept. It is not cleared between packets, so the first flit of a packet counts toggles against the last flit of the previous packet (0 after reset).
- in_ready = 1 in IDLE and RECV, 0 in REPORT. It is combinational from state only.
- IDLE:
  - On accept: len <= 1, tog <= h, idle_cnt <= 0, go to RECV.
  - Otherwise stay.
- RECV:
  - On accept: len <= len+1, tog <= tog+h, idle_cnt <= 0.
  - No accept and idle_cnt == GAP-1: latch the stat_* outputs from len/tog and go to REPORT.
  - No accept otherwise: idle_cnt <= idle_cnt+1.
  - An idle run shorter than GAP does not split the packet.
- REPORT:
  - stat_valid=1. stat_* outputs are held stable until the handshake.
  - On stat_valid & stat_ready: pkt_count <= pkt_count+1, go to IDLE; stat_valid drops the next cycle.
  - Flits offered during REPORT are stalled, not dropped. The first flit accepted in IDLE starts the next packet.
- Latency: with the last flit accepted at edge E0 and no accepts at E1..EGAP, stat_valid is high after edge EGAP.
- Arithmetic:
  - len, tog and pkt_count saturate at 2^CNT_W-1 and never wrap.
  - tog saturates if tog+h would exceed the maximum.
  - stat_len_err is computed on the saturated length.
- Registered outputs: stat_len, stat_toggles, stat_len_err, stat_valid, pkt_count.

Test Plan:
- Alternating flits: after reset, 20 consecutive flits alternating all-ones (42'h3FF_FFFF_FFFF) and all-zeros, then 7 idle cycles -> stat_valid after 7th idle edge; stat_len=20, stat_toggles=840, stat_len_err=0, pkt_count=1 after handshake.
- Short constant packet: 5 flits of 0, then 7 idle -> stat_len=5, stat_toggles=0, stat_len_err=1.
- Gap tolerance: 10 flits, 6 idle cycles, 10 flits, 7 idle -> exactly one report, stat_len=20. Repeating with 7 idle in the middle gives two reports of stat_len=10.
- Backpressure: hold stat_ready=0 for 4 cycles while in_valid=1 -> in_ready=0 and stat_* stable for those cycles. After the handshake, the next flit is accepted in IDLE and begins a new packet; no flit is lost or duplicated.
- Saturation with CNT_W=4: 20 alternating flits -> stat_len=15, stat_toggles=15, stat_len_err=1.
- Reset mid-packet: rst high after 8 flits, then 3 flits and 7 idle -> stat_len=3, pkt_count=1, and the toggles of the first flit are computed against prev_flit=0.
